// File: rtl/ram_pkg.sv
// ram_pkg: shared state encoding, default widths and the parity helper for the RAM write path.
package ram_pkg;

   typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_DRAIN} wr_state_e;

   localparam int DEF_SIZE_DATA = 8;
   localparam int DEF_SIZE_ADDR = 4;

   function automatic logic even_parity(input logic [63:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/ram_wr_done_pipe.sv
// ram_wr_done_pipe: WR_LATENCY-stage shift of the last-write strobe.
// o_pre is the stage that feeds o_done, so the FSM can leave DRAIN on the edge that raises o_done.
module ram_wr_done_pipe #(
   parameter int WR_LATENCY = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_strobe,
   output logic o_pre,
   output logic o_done
);

   logic [WR_LATENCY-1:0] sr;
   logic [WR_LATENCY:0]   chain;

   assign chain  = {sr, i_strobe};
   assign o_pre  = chain[WR_LATENCY-1];
   assign o_done = chain[WR_LATENCY];

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) sr <= '0;
      else sr <= chain[WR_LATENCY-1:0];

endmodule

// File: rtl/ram_write_burst.sv
// ram_write_burst: burst command + valid/ready data beats driving a registered RAM write port.
// Define RAM_WRITE_PARITY_EN to append an even-parity MSB to o_ram_wdata.
module ram_write_burst
   import ram_pkg::*;
#(
   parameter int SIZE_DATA  = DEF_SIZE_DATA,
   parameter int SIZE_ADDR  = DEF_SIZE_ADDR,
   parameter int SIZE_LEN   = 4,
   parameter int WR_LATENCY = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_cmd_valid,
   output logic                 o_cmd_ready,
   input  logic [SIZE_ADDR-1:0] i_cmd_addr,
   input  logic [SIZE_LEN-1:0]  i_cmd_len,
   input  logic                 i_wr_valid,
   output logic                 o_wr_ready,
   input  logic [SIZE_DATA-1:0] i_wr_data,
   output logic                 o_ram_we,
   output logic [SIZE_ADDR-1:0] o_ram_addr,
`ifdef RAM_WRITE_PARITY_EN
   output logic [SIZE_DATA:0]   o_ram_wdata,
`else
   output logic [SIZE_DATA-1:0] o_ram_wdata,
`endif
   output logic                 o_busy,
   output logic                 o_done
);

   localparam logic [SIZE_ADDR-1:0] ADDR_ONE = 1;
   localparam logic [SIZE_LEN-1:0]  LEN_ONE  = 1;

   wr_state_e state, state_nx;
   logic [SIZE_ADDR-1:0]         r_addr;
   logic [SIZE_LEN-1:0]          r_remain;
   logic [$bits(o_ram_wdata)-1:0] wdata_nx;
   logic cmd_take, beat_take, last_take, r_last_we, drain_end;

   assign cmd_take   = state == WR_IDLE && i_cmd_valid && o_cmd_ready;
   assign beat_take  = state == WR_DATA && i_wr_valid;
   assign last_take  = beat_take && r_remain == '0;
   assign o_wr_ready = state == WR_DATA;
   assign o_busy     = state != WR_IDLE;

`ifdef RAM_WRITE_PARITY_EN
   assign wdata_nx = {even_parity(64'(i_wr_data)), i_wr_data};
`else
   assign wdata_nx = i_wr_data;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) state <= WR_IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      if (cmd_take) state_nx = WR_DATA;
      else if (last_take) state_nx = WR_DRAIN;
      else if (state == WR_DRAIN && drain_end) state_nx = WR_IDLE;
   end

   // o_cmd_ready is a flop so it stays low through reset and rises one clock after release
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         o_cmd_ready <= 1'b0;
         r_addr      <= '0;
         r_remain    <= '0;
         r_last_we   <= 1'b0;
         o_ram_we    <= 1'b0;
         o_ram_addr  <= '0;
         o_ram_wdata <= '0;
      end else begin
         o_cmd_ready <= state_nx == WR_IDLE;
         o_ram_we    <= beat_take;
         r_last_we   <= last_take;
         if (cmd_take) begin
            r_addr   <= i_cmd_addr;
            r_remain <= i_cmd_len;
         end else if (beat_take) begin
            r_addr   <= r_addr + ADDR_ONE;
            r_remain <= r_remain - LEN_ONE;
         end
         if (beat_take) begin
            o_ram_addr  <= r_addr;
            o_ram_wdata <= wdata_nx;
         end
      end

   ram_wr_done_pipe #(.WR_LATENCY(WR_LATENCY)) u_done_pipe (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_strobe (r_last_we),
      .o_pre    (drain_end),
      .o_done   (o_done)
   );

endmodule

// File: tb/tb_ram_write_burst.sv
// tb_ram_write_burst: directed bursts checked every cycle against a queue-based burst model.
module tb_ram_write_burst;

   localparam int SD = 8, SA = 4, SL = 4, LAT = 2;
`ifdef RAM_WRITE_PARITY_EN
   localparam int W = SD + 1;
`else
   localparam int W = SD;
`endif

   logic clk = 0, rst_n = 1, run = 0;
   logic cmd_valid = 0, wr_valid = 0;
   logic [SA-1:0] cmd_addr = 0;
   logic [SL-1:0] cmd_len = 0;
   logic [SD-1:0] wr_data = 0;
   logic cmd_ready, wr_ready, ram_we, busy, done;
   logic [SA-1:0] ram_addr;
   logic [W-1:0]  ram_wdata;

   int checks = 0, errors = 0;

   ram_write_burst #(.SIZE_DATA(SD), .SIZE_ADDR(SA), .SIZE_LEN(SL), .WR_LATENCY(LAT)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_cmd_valid (cmd_valid),
      .o_cmd_ready (cmd_ready),
      .i_cmd_addr  (cmd_addr),
      .i_cmd_len   (cmd_len),
      .i_wr_valid  (wr_valid),
      .o_wr_ready  (wr_ready),
      .i_wr_data   (wr_data),
      .o_ram_we    (ram_we),
      .o_ram_addr  (ram_addr),
      .o_ram_wdata (ram_wdata),
      .o_busy      (busy),
      .o_done      (done)
   );

   always #5 clk = ~clk;

   // model: a burst is a list of pending addresses; each accepted beat writes the next one
   int m_cyc = 0, phase = 0, done_at = -1;
   logic e_cmd_ready = 0, e_we = 0, e_done = 0;
   logic [SA-1:0] e_addr = 0;
   logic [W-1:0]  e_data = 0;
   logic [SA-1:0] pend[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase = 0; done_at = -1; pend.delete();
         e_cmd_ready = 0; e_we = 0; e_done = 0; e_addr = 0; e_data = 0;
      end else begin
         m_cyc++;
         e_done = (phase == 2 && m_cyc == done_at);
         if (e_done) phase = 0;
         e_we = 0;
         if (phase == 1 && wr_valid) begin
            e_we = 1;
            e_addr = pend.pop_front();
`ifdef RAM_WRITE_PARITY_EN
            e_data = {^wr_data, wr_data};
`else
            e_data = wr_data;
`endif
            if (pend.size() == 0) begin
               phase = 2;
               done_at = m_cyc + LAT;
            end
         end else if (phase == 0 && e_cmd_ready && cmd_valid) begin
            for (int k = 0; k <= int'(cmd_len); k++) pend.push_back(SA'(int'(cmd_addr) + k));
            phase = 1;
         end
         e_cmd_ready = (phase == 0);
      end
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, m_cyc);
      end
   endtask

   int done_cnt = 0, done_cyc = 0;
   logic busy_at_done = 0;
   logic [SA-1:0] log_a[$];
   logic [W-1:0]  log_d[$];
   int            log_c[$];

   always @(negedge clk) if (run) begin
      chk("cmd_ready", cmd_ready, e_cmd_ready);
      chk("wr_ready", wr_ready, phase == 1);
      chk("busy", busy, phase != 0);
      chk("ram_we", ram_we, e_we);
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_wdata", ram_wdata, e_data);
      chk("done", done, e_done);
      if (ram_we) begin
         log_a.push_back(ram_addr);
         log_d.push_back(ram_wdata);
         log_c.push_back(m_cyc);
      end
      if (done) begin
         done_cnt++;
         done_cyc = m_cyc;
         busy_at_done = busy;
      end
   end

   task automatic clear_log();
      log_a.delete(); log_d.delete(); log_c.delete();
      done_cnt = 0;
   endtask

   task automatic send_cmd(input logic [SA-1:0] a, input logic [SL-1:0] l);
      int t = 0;
      while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("timeout_cmd_ready", 0, 1);
      cmd_addr = a; cmd_len = l; cmd_valid = 1;
      @(negedge clk);
      cmd_valid = 0;
   endtask

   task automatic beat(input logic [SD-1:0] d);
      int t = 0;
      while (!wr_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("timeout_wr_ready", 0, 1);
      wr_valid = 1; wr_data = d;
      @(negedge clk);
      wr_valid = 0;
   endtask

   task automatic wait_done(input int n);
      int t = 0;
      while (done_cnt < n && t < 60) begin @(negedge clk); t++; end
      if (t >= 60) chk("timeout_done", done_cnt, n);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #1 rst_n = 0; run = 1;
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      @(negedge clk);
      #2 rst_n = 1;
      @(negedge clk);
      chk("cmd_ready_after_release", cmd_ready, 1);

      // back-to-back burst at 3..6
      clear_log();
      send_cmd(3, 3);
      for (int i = 0; i < 4; i++) beat(SD'(8'hA0 + i));
      wait_done(1);
      chk("t1_writes", log_a.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("t1_addr", log_a[i], 3 + i);
         chk("t1_data", log_d[i][SD-1:0], 8'hA0 + i);
         if (i > 0) chk("t1_gap", log_c[i] - log_c[i-1], 1);
      end
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_done_latency", done_cyc - log_c[3], 2);
      chk("t1_busy_at_done", busy_at_done, 0);

      // address wrap
      clear_log();
      send_cmd(14, 3);
      for (int i = 0; i < 4; i++) beat(SD'(8'h10 * i + 1));
      wait_done(1);
      chk("t2_writes", log_a.size(), 4);
      chk("t2_addr0", log_a[0], 14);
      chk("t2_addr1", log_a[1], 15);
      chk("t2_addr2", log_a[2], 0);
      chk("t2_addr3", log_a[3], 1);

      // stalls of three cycles between beats
      clear_log();
      send_cmd(10, 2);
      beat(8'h11); repeat (3) @(negedge clk);
      beat(8'h22); repeat (3) @(negedge clk);
      beat(8'h33);
      wait_done(1);
      chk("t3_writes", log_a.size(), 3);
      chk("t3_addr2", log_a[2], 12);
      chk("t3_data1", log_d[1][SD-1:0], 8'h22);
      chk("t3_spacing", log_c[1] - log_c[0], 4);
      chk("t3_done_cnt", done_cnt, 1);

      // inputs outside their accepting state are ignored
      clear_log();
      wr_valid = 1; wr_data = 8'hEE;
      repeat (3) @(negedge clk);
      wr_valid = 0;
      send_cmd(8, 1);
      cmd_valid = 1; cmd_addr = 0; cmd_len = 7;
      chk("t4_cmd_ready_in_data", cmd_ready, 0);
      beat(8'h5A);
      beat(8'h6B);
      cmd_valid = 0;
      wr_valid = 1; wr_data = 8'hFF;
      @(negedge clk);
      wr_valid = 0;
      wait_done(1);
      chk("t4_writes", log_a.size(), 2);
      chk("t4_addr0", log_a[0], 8);
      chk("t4_addr1", log_a[1], 9);
      chk("t4_data1", log_d[1][SD-1:0], 8'h6B);
      chk("t4_done_cnt", done_cnt, 1);

      // reset in the middle of a burst
      clear_log();
      send_cmd(2, 3);
      beat(8'hC1);
      beat(8'hC2);
      #2 rst_n = 0;
      #1;
      chk("t5_we_async", ram_we, 0);
      chk("t5_addr_async", ram_addr, 0);
      chk("t5_data_async", ram_wdata, 0);
      chk("t5_busy_async", busy, 0);
      chk("t5_wr_ready_async", wr_ready, 0);
      @(negedge clk);
      #2 rst_n = 1;
      chk("t5_aborted_writes", log_a.size(), 2);
      clear_log();
      repeat (5) @(negedge clk);
      chk("t5_no_stale_done", done_cnt, 0);
      send_cmd(5, 0);
      beat(8'h77);
      wait_done(1);
      repeat (4) @(negedge clk);
      chk("t5_writes", log_a.size(), 1);
      chk("t5_addr", log_a[0], 5);
      chk("t5_data", log_d[0][SD-1:0], 8'h77);
      chk("t5_done_cnt", done_cnt, 1);

      // maximum burst wraps the full address space
      clear_log();
      send_cmd(4, 15);
      for (int i = 0; i < 16; i++) beat(SD'(i * 3));
      wait_done(1);
      chk("t6_writes", log_a.size(), 16);
      chk("t6_addr11", log_a[11], 15);
      chk("t6_addr12", log_a[12], 0);
      chk("t6_addr15", log_a[15], 3);
      chk("t6_data15", log_d[15][SD-1:0], 45);
      chk("t6_done_cnt", done_cnt, 1);

`ifdef RAM_WRITE_PARITY_EN
      clear_log();
      send_cmd(0, 1);
      beat(8'hA5);
      beat(8'h01);
      wait_done(1);
      chk("t7_parity_a5", log_d[0], 9'h0A5);
      chk("t7_parity_01", log_d[1], 9'h101);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
